// File: rtl/cond_jump_seq_if.sv
// Instruction/flag inputs and sequencer strobes of cond_jump_seq, bundled as one port.
// No backpressure: the master watches busy and the slave drops instructions while busy.
interface cond_jump_seq_if #(
    parameter int OPW   = 4,
    parameter int NCOND = 4
);
    logic [OPW-1:0]   instruct;
    logic             instr_valid;
    logic [NCOND-1:0] flags;
    logic             enabling;
    logic             enabling_sta;
    logic             openpulse;
    logic             busy;
    logic             done;

    modport master (
        output instruct, instr_valid, flags,
        input  enabling, enabling_sta, openpulse, busy, done
    );

    modport slave (
        input  instruct, instr_valid, flags,
        output enabling, enabling_sta, openpulse, busy, done
    );
endinterface

// File: rtl/cond_jump_seq.sv
// Conditional-jump sequencer: done comes T_SETUP+T_OPEN+3 cycles after accept; busy drops instructions.
// COND_JUMP_POLARITY_EN makes instruct[OPW-2] a polarity bit (1 = jump-if-set).
module cond_jump_seq #(
    parameter int OPW     = 4,
    parameter int NCOND   = 4,
    parameter int T_SETUP = 8,
    parameter int T_OPEN  = 4
) (
    input  logic           pulses,
    input  logic           rst_n,
    cond_jump_seq_if.slave bus
);
`ifdef COND_JUMP_POLARITY_EN
    localparam int IW = OPW - 2;
`else
    localparam int IW = OPW - 1;
`endif
    localparam int TMAX = (T_SETUP > T_OPEN) ? T_SETUP : T_OPEN;
    localparam int CW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] OPEN_LAST  = CW'(T_OPEN - 1);

    typedef enum logic [2:0] {IDLE, SETUP, OPEN, GAP, LATCH, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [IW-1:0]  idx;
    logic           idx_ok;
    logic           sel_flag;
    logic           taken_in;
    logic           taken;
    logic           accept;
    logic           enabling_q;
    logic           enabling_sta_q;

    assign idx = bus.instruct[IW-1:0];

    // Out-of-range indices simply never match, which doubles as the range check.
    always_comb begin
        idx_ok   = 1'b0;
        sel_flag = 1'b0;
        for (int i = 0; i < NCOND; i++) begin
            if (idx == IW'(i)) begin
                idx_ok   = 1'b1;
                sel_flag = bus.flags[i];
            end
        end
    end

`ifdef COND_JUMP_POLARITY_EN
    assign taken_in = bus.instruct[OPW-2] ? sel_flag : !sel_flag;
`else
    assign taken_in = !sel_flag;
`endif

    assign accept = bus.instr_valid && (state == IDLE) && !bus.instruct[OPW-1] && idx_ok;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE:  if (accept) state_nxt = SETUP;
            SETUP: begin
                if (cnt == SETUP_LAST) state_nxt = OPEN;
                else                   cnt_nxt   = cnt + CW'(1);
            end
            OPEN: begin
                if (cnt == OPEN_LAST) state_nxt = GAP;
                else                  cnt_nxt   = cnt + CW'(1);
            end
            GAP:     state_nxt = LATCH;
            LATCH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pulses or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Jump decision is frozen at accept so later flag changes cannot disturb it.
    always_ff @(posedge pulses or negedge rst_n) begin
        if (!rst_n) begin
            taken          <= 1'b0;
            enabling_q     <= 1'b0;
            enabling_sta_q <= 1'b0;
        end else if (accept) begin
            taken          <= taken_in;
            enabling_q     <= 1'b0;
            enabling_sta_q <= 1'b0;
        end else if (state == GAP) begin
            enabling_q     <= 1'b1;
            enabling_sta_q <= taken;
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.openpulse    = (state == OPEN) && taken;
    assign bus.enabling     = enabling_q;
    assign bus.enabling_sta = enabling_sta_q;
endmodule

// File: tb/tb_cond_jump_seq.sv
// Bench for cond_jump_seq: directed scenarios then random traffic against a cycle-offset reference model.
module tb_cond_jump_seq;
    localparam int OPW     = 4;
    localparam int NCOND   = 4;
    localparam int T_SETUP = 8;
    localparam int T_OPEN  = 4;
    localparam int LAT     = T_SETUP + T_OPEN + 3;

    logic pulses = 1'b0;
    logic rst_n  = 1'b0;

    cond_jump_seq_if #(.OPW(OPW), .NCOND(NCOND)) bus ();

    cond_jump_seq #(
        .OPW(OPW), .NCOND(NCOND), .T_SETUP(T_SETUP), .T_OPEN(T_OPEN)
    ) dut (
        .pulses (pulses),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 pulses = ~pulses;

    // Model: k = rising edges since the accept edge (0 = idle).
    int k       = 0;
    bit m_taken = 1'b0;
    bit m_en    = 1'b0;
    bit m_ensta = 1'b0;
    int n_chk   = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        bit e_busy, e_open, e_done;
        e_busy = (k >= 1) && (k <= LAT);
        e_open = m_taken && (k > T_SETUP) && (k <= T_SETUP + T_OPEN);
        e_done = (k == LAT);
        chk($sformatf("%s.busy k=%0d", tag, k),         bus.busy,         e_busy);
        chk($sformatf("%s.openpulse k=%0d", tag, k),    bus.openpulse,    e_open);
        chk($sformatf("%s.done k=%0d", tag, k),         bus.done,         e_done);
        chk($sformatf("%s.enabling k=%0d", tag, k),     bus.enabling,     m_en);
        chk($sformatf("%s.enabling_sta k=%0d", tag, k), bus.enabling_sta, m_ensta);
    endtask

    // Called just after a falling edge: drive, take one rising edge, update model, check.
    task automatic step(input logic v, input logic [OPW-1:0] ins, input logic [NCOND-1:0] fl,
                        input string tag);
        int  idx;
        bit  pol, ok, f;
        bus.instr_valid = v;
        bus.instruct    = ins;
        bus.flags       = fl;
`ifdef COND_JUMP_POLARITY_EN
        pol = ins[OPW-2];
        idx = int'(ins[OPW-3:0]);
`else
        pol = 1'b0;
        idx = int'(ins[OPW-2:0]);
`endif
        ok = v && !ins[OPW-1] && (idx < NCOND);
        f  = ok ? fl[idx] : 1'b0;
        @(posedge pulses);
        if (k >= 1 && k <= LAT) begin
            k = (k == LAT) ? 0 : k + 1;
            if (k == T_SETUP + T_OPEN + 2) begin
                m_en    = 1'b1;
                m_ensta = m_taken;
            end
        end else if (ok) begin
            k       = 1;
            m_taken = pol ? f : !f;
            m_en    = 1'b0;
            m_ensta = 1'b0;
        end
        @(negedge pulses);
        check_all(tag);
    endtask

    // Asserts reset mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        k = 0; m_taken = 1'b0; m_en = 1'b0; m_ensta = 1'b0;
        check_all({tag, ".async"});
        @(negedge pulses);
        check_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    task automatic idle_run(input int n, input logic [NCOND-1:0] fl, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, '0, fl, tag);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instruct    = '0;
        bus.flags       = '0;
        @(negedge pulses);
        do_reset("reset");

        // Jump-if-clear taken
        step(1'b1, 4'b0000, 4'b0000, "taken");
        idle_run(LAT + 2, 4'b0000, "taken");

        // Flag set: not taken
        step(1'b1, 4'b0000, 4'b0001, "nottaken");
        idle_run(LAT + 2, 4'b0001, "nottaken");

        // Flag toggles at cycle 3, extra valid at cycle 5 and during DONE
        step(1'b1, 4'b0000, 4'b0000, "busyign");
        for (int i = 1; i <= LAT + 1; i++)
            step((i == 5) || (i == LAT), 4'b0000, (i >= 3) ? 4'b0001 : 4'b0000, "busyign");
        // Resume right after DONE
        step(1'b1, 4'b0010, 4'b1011, "resume");
        idle_run(LAT + 1, 4'b0000, "resume");

        // Ignored opcodes: out-of-range index (default build) and MSB=1
        step(1'b1, 4'b0101, 4'b0000, "badidx");
        idle_run(LAT + 1, 4'b0000, "badidx");
        step(1'b1, 4'b1000, 4'b0000, "msb1");
        idle_run(2, 4'b0000, "msb1");

        // Reset during OPEN, then a normal sequence right after release
        step(1'b1, 4'b0001, 4'b0000, "abort");
        idle_run(9, 4'b0000, "abort");
        do_reset("abort.rst");
        step(1'b1, 4'b0011, 4'b0111, "postrst");
        idle_run(LAT + 1, 4'b0000, "postrst");

`ifdef COND_JUMP_POLARITY_EN
        step(1'b1, 4'b0100, 4'b0001, "polset");
        idle_run(LAT + 1, 4'b0001, "polset");
`endif

        // Random traffic, flags changing freely
        for (int i = 0; i < 900; i++)
            step($urandom_range(0, 2) == 0, OPW'($urandom), NCOND'($urandom), "rnd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cond_jump_seq.md
COND_JUMP_SEQ -- requirements
Module: cond_jump_seq

Interface
REQ-001 The block SHALL have parameter OPW, default 4, giving the instruct width (minimum 2).
REQ-002 The block SHALL have parameter NCOND, default 4, giving the number of condition flags (1..2^(OPW-1)).
REQ-003 The block SHALL have parameter T_SETUP, default 8, giving the cycles from accept to openpulse rise (minimum 1).
REQ-004 The block SHALL have parameter T_OPEN, default 4, giving the openpulse width in cycles (minimum 1).
REQ-005 pulses  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 instruct  in  OPW  opcode: MSB=0 means jump class; bits [OPW-2:0] are the condition index.
REQ-008 instr_valid  in  1  instruct is valid this cycle.
REQ-009 flags  in  NCOND  condition flags; flags[0] is the overflow/status flag.
REQ-010 enabling  out  1  decoded jump instruction latched (check enable).
REQ-011 enabling_sta  out  1  jump taken; load enable for the program counter.
REQ-012 openpulse  out  1  counter-load strobe, T_OPEN cycles wide, taken jumps only.
REQ-013 busy  out  1  sequence in progress; new instructions are ignored.
REQ-014 done  out  1  one-cycle completion strobe.

Function
REQ-015 Accept SHALL occur when instr_valid=1, busy=0, instruct MSB=0 and the index is less than NCOND.
REQ-016 Any other instr_valid cycle SHALL be ignored with no output change, including an index >= NCOND.
REQ-017 On accept, the block SHALL latch idx and sample f=flags[idx]; taken = !f (jump-if-clear).
REQ-018 The FSM SHALL have states IDLE, SETUP, OPEN, GAP, LATCH, DONE.
REQ-019 IDLE->SETUP on accept; SETUP lasts T_SETUP cycles; OPEN lasts T_OPEN; GAP 1; LATCH 1; DONE 1; then IDLE.
REQ-020 openpulse SHALL be 1 exactly in OPEN when taken=1, and 0 otherwise.
REQ-021 In LATCH the block SHALL register enabling=1 and enabling_sta=taken; both hold until the next accept or reset.
REQ-022 At the next accept, enabling and enabling_sta SHALL clear on the accept edge.
REQ-023 busy SHALL be 1 in every state except IDLE; done SHALL be 1 only in DONE.
REQ-024 Total latency from the accept edge to done=1 SHALL be T_SETUP+T_OPEN+3 cycles.
REQ-025 Flag changes after accept SHALL NOT affect taken or openpulse.
REQ-026 instr_valid during DONE SHALL be ignored; acceptance resumes in IDLE, the cycle after done.
REQ-027 Phase counters SHALL be sized by $clog2 of the maximum of T_SETUP and T_OPEN plus 1, with no wrap within a phase.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, with enabling, enabling_sta, openpulse, busy and done all 0 and counters 0.
REQ-029 Reset mid-sequence SHALL abort without a done strobe; the first accept is possible on the first rising edge after release.

Configuration
REQ-030 With macro COND_JUMP_POLARITY_EN defined, instruct[OPW-2] SHALL be a polarity bit: 1 = jump-if-set (taken=f), 0 = jump-if-clear. The index then uses bits [OPW-3:0], and this mode requires OPW>=3.
REQ-031 Without COND_JUMP_POLARITY_EN, all of bits [OPW-2:0] SHALL form the index and every jump SHALL be jump-if-clear.

Verification
REQ-032 Defaults: instruct=4'b0000, flags=4'b0000, one-cycle valid at cycle 0 -> busy from cycle 1; openpulse high cycles 9-12; enabling=enabling_sta=1 from cycle 14; done at cycle 15.
REQ-033 Same stimulus with flags[0]=1 -> openpulse never rises; enabling=1, enabling_sta=0; done at cycle 15.
REQ-034 Second valid at cycle 5 and flags[0] toggled at cycle 3 -> second valid ignored, taken unchanged, single done.
REQ-035 rst_n low at cycle 10 during OPEN -> all outputs 0 asynchronously, no done; new accept after release completes normally.
REQ-036 Index 3'b101 with NCOND=4, or MSB=1 -> no busy, outputs unchanged.
REQ-037 With COND_JUMP_POLARITY_EN, instruct=4'b0100 and flags[0]=1 -> taken, openpulse high for 4 cycles.
